// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the PC prediction slice.
//   - pc_action_e      : PC action codes used by the fetch stage.
//   - COND_*           : resolve_cond encodings (Never=0 .. Lez=7).
//   - CTR_*            : 2-bit saturating counter reset/allocate/limit values.
//   - ctr_update()     : saturating counter step used by the table update.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_ACT_SEQ    = 2'd0,
    PC_ACT_BRANCH = 2'd1,
    PC_ACT_JUMP   = 2'd2,
    PC_ACT_TRAP   = 2'd3
  } pc_action_e;

  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_ALWAYS = 3'd1;
  localparam logic [2:0] COND_EQ     = 3'd2;
  localparam logic [2:0] COND_NE     = 3'd3;
  localparam logic [2:0] COND_GEZ    = 3'd4;
  localparam logic [2:0] COND_LTZ    = 3'd5;
  localparam logic [2:0] COND_GTZ    = 3'd6;
  localparam logic [2:0] COND_LEZ    = 3'd7;

  // Counter value after reset: weakly not-taken.
  localparam logic [1:0] CTR_RESET        = 2'd1;
  // Unconditional jumps start strongly taken, conditional branches weakly taken.
  localparam logic [1:0] CTR_ALLOC_ALWAYS = 2'd3;
  localparam logic [1:0] CTR_ALLOC_COND   = 2'd2;
  localparam logic [1:0] CTR_MAX          = 2'd3;
  localparam logic [1:0] CTR_MIN          = 2'd0;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) res = ctr + 2'd1;
      else                res = ctr;
    end else begin
      if (ctr != CTR_MIN) res = ctr - 2'd1;
      else                res = ctr;
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_condition.sv
// pc_condition: combinational evaluation of the actual branch outcome.
//   cond_i     : resolve_cond encoding from pc_pkg (COND_*)
//   zeroflag_i : ALU zero/compare flag
//   zeroreg_i  : source register equals zero
//   actual_o   : 1 when the branch/jump is actually taken
module pc_condition
  import pc_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic       zeroflag_i,
  input  logic       zeroreg_i,
  output logic       actual_o
);

  // Map each condition kind onto the flags it depends on.
  always_comb begin
    actual_o = 1'b0;
    case (cond_i)
      COND_NEVER:  actual_o = 1'b0;
      COND_ALWAYS: actual_o = 1'b1;
      COND_EQ:     actual_o = zeroflag_i;
      COND_NE:     actual_o = !zeroflag_i;
      COND_GEZ:    actual_o = !zeroflag_i;
      COND_LTZ:    actual_o = zeroflag_i;
      COND_GTZ:    actual_o = !zeroflag_i && !zeroreg_i;
      COND_LEZ:    actual_o = zeroflag_i || zeroreg_i;
      default:     actual_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_predict.sv
// pc_predict: direct-mapped branch target predictor with 2-bit counters.
//   clock, reset_n          : rising-edge clock, async active-low reset
//   fetch_pc                : PC looked up combinationally
//   predict_hit/_taken/_target : lookup result (target = fetch_pc+4 if not taken)
//   resolve_*               : resolving branch/jump, drives table update
//   zeroflag, zeroreg       : flags for outcome evaluation
//   redirect_valid/_pc      : registered one-cycle mispredict redirect
//   stat_clear              : synchronous clear of both statistics counters
//   stat_branches/_mispredicts : saturating statistics
module pc_predict
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ENTRIES   = 16,
  parameter int STAT_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     fetch_pc,
  output logic                 predict_hit,
  output logic                 predict_taken,
  output logic [WIDTH-1:0]     predict_target,
  input  logic                 resolve_valid,
  input  logic [WIDTH-1:0]     resolve_pc,
  input  logic [2:0]           resolve_cond,
  input  logic                 zeroflag,
  input  logic                 zeroreg,
  input  logic [WIDTH-1:0]     resolve_target,
  input  logic                 resolve_pred_taken,
  input  logic [WIDTH-1:0]     resolve_pred_target,
  output logic                 redirect_valid,
  output logic [WIDTH-1:0]     redirect_pc,
  input  logic                 stat_clear,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;
  localparam logic [WIDTH-1:0]     PC_STEP  = WIDTH'(4);
  localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};
  localparam logic [STAT_BITS-1:0] STAT_ONE = {{(STAT_BITS-1){1'b0}}, 1'b1};

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX-1:0]   fetch_idx_s, res_idx_s;
  logic [TAG_W-1:0] fetch_tag_s, res_tag_s;
  logic             res_hit_s, actual_s, upd_s, mispredict_s;

  logic             tbl_we_s;
  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  logic [WIDTH-1:0] target_d;
  logic [1:0]       ctr_d;

  logic                 redirect_valid_q;
  logic [WIDTH-1:0]     redirect_pc_q, redirect_pc_d;
  logic [STAT_BITS-1:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  // Instruction alignment bits never take part in indexing or tagging.
  logic lowbits_unused_s;
  assign lowbits_unused_s = ^{fetch_pc[1:0], resolve_pc[1:0]};

  assign fetch_idx_s = fetch_pc[IDX+1:2];
  assign fetch_tag_s = fetch_pc[WIDTH-1:IDX+2];
  assign res_idx_s   = resolve_pc[IDX+1:2];
  assign res_tag_s   = resolve_pc[WIDTH-1:IDX+2];

  // Lookup reads only registered table state, so a same-cycle update is not visible.
  assign predict_hit    = valid_q[fetch_idx_s] && (tag_q[fetch_idx_s] == fetch_tag_s);
  assign predict_taken  = predict_hit && ctr_q[fetch_idx_s][1];
  assign predict_target = predict_taken ? target_q[fetch_idx_s] : (fetch_pc + PC_STEP);

  pc_condition u_cond (
    .cond_i     (resolve_cond),
    .zeroflag_i (zeroflag),
    .zeroreg_i  (zeroreg),
    .actual_o   (actual_s)
  );

  assign res_hit_s    = valid_q[res_idx_s] && (tag_q[res_idx_s] == res_tag_s);
  assign upd_s        = resolve_valid && (resolve_cond != COND_NEVER);
  assign mispredict_s = upd_s && ((actual_s != resolve_pred_taken) ||
                                  (actual_s && (resolve_target != resolve_pred_target)));

  // Next contents of the resolving entry: train on hit, allocate on taken miss.
  always_comb begin
    tbl_we_s = 1'b0;
    valid_d  = valid_q[res_idx_s];
    tag_d    = tag_q[res_idx_s];
    target_d = target_q[res_idx_s];
    ctr_d    = ctr_q[res_idx_s];
    if (upd_s) begin
      if (res_hit_s) begin
        tbl_we_s = 1'b1;
        ctr_d    = ctr_update(ctr_q[res_idx_s], actual_s);
        if (actual_s) target_d = resolve_target;
        else          target_d = target_q[res_idx_s];
      end else if (actual_s) begin
        tbl_we_s = 1'b1;
        valid_d  = 1'b1;
        tag_d    = res_tag_s;
        target_d = resolve_target;
        if (resolve_cond == COND_ALWAYS) ctr_d = CTR_ALLOC_ALWAYS;
        else                             ctr_d = CTR_ALLOC_COND;
      end else begin
        tbl_we_s = 1'b0;
      end
    end else begin
      tbl_we_s = 1'b0;
    end
  end

  // Redirect PC and saturating statistics; clear wins over increment.
  always_comb begin
    redirect_pc_d = redirect_pc_q;
    stat_br_d     = stat_br_q;
    stat_mp_d     = stat_mp_q;
    if (mispredict_s) redirect_pc_d = actual_s ? resolve_target : (resolve_pc + PC_STEP);
    else              redirect_pc_d = redirect_pc_q;
    if (stat_clear) begin
      stat_br_d = {STAT_BITS{1'b0}};
      stat_mp_d = {STAT_BITS{1'b0}};
    end else begin
      if (upd_s && (stat_br_q != STAT_MAX)) stat_br_d = stat_br_q + STAT_ONE;
      else                                  stat_br_d = stat_br_q;
      if (mispredict_s && (stat_mp_q != STAT_MAX)) stat_mp_d = stat_mp_q + STAT_ONE;
      else                                         stat_mp_d = stat_mp_q;
    end
  end

  // Prediction table storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= {WIDTH{1'b0}};
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (tbl_we_s) begin
      valid_q[res_idx_s]  <= valid_d;
      tag_q[res_idx_s]    <= tag_d;
      target_q[res_idx_s] <= target_d;
      ctr_q[res_idx_s]    <= ctr_d;
    end
  end

  // Redirect strobe and statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= {WIDTH{1'b0}};
      stat_br_q        <= {STAT_BITS{1'b0}};
      stat_mp_q        <= {STAT_BITS{1'b0}};
    end else begin
      redirect_valid_q <= mispredict_s;
      redirect_pc_q    <= redirect_pc_d;
      stat_br_q        <= stat_br_d;
      stat_mp_q        <= stat_mp_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_pc_predict.sv
// tb_pc_predict: directed scenarios plus a randomized run against a
// behavioural table model for pc_predict (default parameters).
module tb_pc_predict;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        predict_hit, predict_taken;
  logic [31:0] predict_target;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = 32'h0;
  logic [2:0]  resolve_cond = 3'd0;
  logic        zeroflag = 1'b0, zeroreg = 1'b0;
  logic [31:0] resolve_target = 32'h0;
  logic        resolve_pred_taken = 1'b0;
  logic [31:0] resolve_pred_target = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stat_clear = 1'b0;
  logic [15:0] stat_branches, stat_mispredicts;

  int n_cmp = 0;
  int n_bad = 0;

  pc_predict dut (
    .clock(clock), .reset_n(reset_n), .fetch_pc(fetch_pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken), .predict_target(predict_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_cond(resolve_cond),
    .zeroflag(zeroflag), .zeroreg(zeroreg), .resolve_target(resolve_target),
    .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stat_clear(stat_clear),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    resolve_valid = 1'b0;
    stat_clear    = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [2:0] c, input logic zf, input logic zr,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    resolve_valid = 1'b1; resolve_pc = pc; resolve_cond = c; zeroflag = zf; zeroreg = zr;
    resolve_target = tgt; resolve_pred_taken = pt; resolve_pred_target = ptgt;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    fetch_pc = 32'h00400010;
    tick(); tick();
    n_cmp++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || stat_branches !== 16'h0 ||
        stat_mispredicts !== 16'h0 || predict_hit !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: rv=%b rpc=%h br=%h mp=%h hit=%b (want 0s)",
               redirect_valid, redirect_pc, stat_branches, stat_mispredicts, predict_hit);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (predict_hit !== 1'b0 || predict_taken !== 1'b0 || predict_target !== 32'h00400014) begin
      n_bad++;
      $display("FAIL reset_lookup: hit=%b taken=%b tgt=%h want 0 0 00400014",
               predict_hit, predict_taken, predict_target);
    end
  endtask

  task automatic test_allocate();
    drive(32'h00400010, 3'd3, 1'b0, 1'b0, 32'h00400100, 1'b0, 32'h0);
    fetch_pc = 32'h00400010;
    #1;
    n_cmp++;
    if (predict_hit !== 1'b0) begin
      n_bad++; $display("FAIL same_cycle_lookup: hit=%b want 0", predict_hit);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00400100) begin
      n_bad++; $display("FAIL alloc_redirect: rv=%b rpc=%h want 1 00400100", redirect_valid, redirect_pc);
    end
    n_cmp++;
    if (predict_hit !== 1'b1 || predict_taken !== 1'b1 || predict_target !== 32'h00400100) begin
      n_bad++;
      $display("FAIL alloc_lookup: hit=%b taken=%b tgt=%h want 1 1 00400100",
               predict_hit, predict_taken, predict_target);
    end
    n_cmp++;
    if (stat_branches !== 16'd1 || stat_mispredicts !== 16'd1) begin
      n_bad++; $display("FAIL alloc_stats: br=%0d mp=%0d want 1 1", stat_branches, stat_mispredicts);
    end
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h00400100) begin
      n_bad++; $display("FAIL redirect_hold: rv=%b rpc=%h want 0 00400100", redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_counter_decay();
    stat_clear = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      drive(32'h00400010, 3'd2, 1'b0, 1'b0, 32'h00400100, 1'b0, 32'h0);
      tick();
      idle();
      #1;
      n_cmp++;
      if (predict_hit !== 1'b1 || predict_taken !== 1'b0 || predict_target !== 32'h00400014 ||
          redirect_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL decay_%0d: hit=%b taken=%b tgt=%h rv=%b want 1 0 00400014 0",
                 k, predict_hit, predict_taken, predict_target, redirect_valid);
      end
    end
    n_cmp++;
    if (stat_branches !== 16'd3 || stat_mispredicts !== 16'd0) begin
      n_bad++; $display("FAIL decay_stats: br=%0d mp=%0d want 3 0", stat_branches, stat_mispredicts);
    end
    // Counter sits at 0: one taken gives 1 (not taken), a second gives 2 (taken).
    drive(32'h00400010, 3'd1, 1'b0, 1'b0, 32'h00400180, 1'b1, 32'h00400180);
    tick();
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_bad++; $display("FAIL floor_check: taken=%b want 0", predict_taken);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h00400180 || redirect_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL retrain: taken=%b tgt=%h rv=%b want 1 00400180 0", predict_taken, predict_target, redirect_valid);
    end
  endtask

  task automatic test_alias();
    do_reset();
    drive(32'h00400010, 3'd1, 1'b0, 1'b0, 32'h00400200, 1'b1, 32'h00400200);
    tick();
    drive(32'h00400050, 3'd1, 1'b0, 1'b0, 32'h00400300, 1'b1, 32'h00400300);
    tick();
    idle();
    fetch_pc = 32'h00400010;
    #1;
    n_cmp++;
    if (predict_hit !== 1'b0 || predict_target !== 32'h00400014) begin
      n_bad++; $display("FAIL alias_old: hit=%b tgt=%h want 0 00400014", predict_hit, predict_target);
    end
    fetch_pc = 32'h00400050;
    #1;
    n_cmp++;
    if (predict_hit !== 1'b1 || predict_taken !== 1'b1 || predict_target !== 32'h00400300) begin
      n_bad++;
      $display("FAIL alias_new: hit=%b taken=%b tgt=%h want 1 1 00400300", predict_hit, predict_taken, predict_target);
    end
  endtask

  task automatic test_gtz_lez();
    drive(32'h00400080, 3'd6, 1'b0, 1'b1, 32'h00400400, 1'b1, 32'h00400400);
    fetch_pc = 32'h00400080;
    tick();
    #1;
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00400084 || predict_hit !== 1'b0) begin
      n_bad++;
      $display("FAIL gtz: rv=%b rpc=%h hit=%b want 1 00400084 0", redirect_valid, redirect_pc, predict_hit);
    end
    drive(32'h00400080, 3'd7, 1'b0, 1'b1, 32'h00400400, 1'b0, 32'h0);
    tick();
    idle();
    #1;
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00400400 || predict_taken !== 1'b1) begin
      n_bad++;
      $display("FAIL lez: rv=%b rpc=%h taken=%b want 1 00400400 1", redirect_valid, redirect_pc, predict_taken);
    end
  endtask

  task automatic test_never();
    logic [15:0] br0, mp0;
    br0 = 16'd0; mp0 = 16'd0;
    tick();
    br0 = stat_branches; mp0 = stat_mispredicts;
    drive(32'h004000C0, 3'd0, 1'b1, 1'b1, 32'h00400500, 1'b1, 32'h00400600);
    tick();
    drive(32'h004000C0, 3'd1, 1'b1, 1'b1, 32'h00400500, 1'b0, 32'h0);
    resolve_valid = 1'b0;
    fetch_pc = 32'h004000C0;
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b0 || predict_hit !== 1'b0 || stat_branches !== br0 || stat_mispredicts !== mp0) begin
      n_bad++;
      $display("FAIL never_noop: rv=%b hit=%b br=%0d mp=%0d want 0 0 %0d %0d",
               redirect_valid, predict_hit, stat_branches, stat_mispredicts, br0, mp0);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h00400100, 3'd1, 1'b0, 1'b0, 32'h00401000, 1'b0, 32'h0);
    tick();
    drive(32'h00400104, 3'd2, 1'b0, 1'b0, 32'h00402000, 1'b1, 32'h00402000);
    #1;
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00401000) begin
      n_bad++; $display("FAIL b2b_first: rv=%b rpc=%h want 1 00401000", redirect_valid, redirect_pc);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00400108) begin
      n_bad++; $display("FAIL b2b_second: rv=%b rpc=%h want 1 00400108", redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_random();
    bit          mvalid [16];
    logic [31:0] mtag [16];
    logic [31:0] mtarget [16];
    int          mctr [16];
    int          mbr, mmp;
    logic        exp_rv, exp_hit, exp_taken, act, mis, hit;
    logic [31:0] exp_rpc, exp_tgt;
    int          i, mi;
    do_reset();
    for (int e = 0; e < 16; e++) begin
      mvalid[e] = 1'b0; mtag[e] = 32'h0; mtarget[e] = 32'h0; mctr[e] = 1;
    end
    mbr = 0; mmp = 0; exp_rpc = 32'h0;
    for (int n = 0; n < 400; n++) begin
      fetch_pc = 32'h00400000 + 32'($urandom_range(0, 1)) * 32'h40 + 32'($urandom_range(0, 3)) * 32'h4;
      resolve_valid = ($urandom_range(0, 3) != 0);
      resolve_pc = 32'h00400000 + 32'($urandom_range(0, 1)) * 32'h40 + 32'($urandom_range(0, 3)) * 32'h4;
      resolve_cond = 3'($urandom_range(0, 7));
      zeroflag = 1'($urandom_range(0, 1));
      zeroreg = 1'($urandom_range(0, 1));
      resolve_target = 32'h00500000 + 32'($urandom_range(0, 3)) * 32'h10;
      resolve_pred_taken = 1'($urandom_range(0, 1));
      resolve_pred_target = 32'h00500000 + 32'($urandom_range(0, 3)) * 32'h10;
      stat_clear = ($urandom_range(0, 31) == 0);
      #1;
      mi = int'(fetch_pc[5:2]);
      exp_hit = mvalid[mi] && (mtag[mi] == (fetch_pc >> 6));
      exp_taken = exp_hit && (mctr[mi] >= 2);
      exp_tgt = exp_taken ? mtarget[mi] : fetch_pc + 32'd4;
      n_cmp++;
      if (predict_hit !== exp_hit || predict_taken !== exp_taken || predict_target !== exp_tgt) begin
        n_bad++;
        $display("FAIL rand_lookup[%0d]: hit=%b taken=%b tgt=%h want %b %b %h",
                 n, predict_hit, predict_taken, predict_target, exp_hit, exp_taken, exp_tgt);
      end
      exp_rv = 1'b0;
      if (resolve_valid && resolve_cond != 3'd0) begin
        case (resolve_cond)
          3'd1: act = 1'b1;
          3'd2: act = zeroflag;
          3'd3: act = !zeroflag;
          3'd4: act = !zeroflag;
          3'd5: act = zeroflag;
          3'd6: act = !zeroflag && !zeroreg;
          3'd7: act = zeroflag || zeroreg;
          default: act = 1'b0;
        endcase
        mis = (act != resolve_pred_taken) || (act && resolve_target != resolve_pred_target);
        i = int'(resolve_pc[5:2]);
        hit = mvalid[i] && (mtag[i] == (resolve_pc >> 6));
        if (hit) begin
          mctr[i] = act ? ((mctr[i] < 3) ? mctr[i] + 1 : 3) : ((mctr[i] > 0) ? mctr[i] - 1 : 0);
          if (act) mtarget[i] = resolve_target;
        end else if (act) begin
          mvalid[i] = 1'b1; mtag[i] = resolve_pc >> 6; mtarget[i] = resolve_target;
          mctr[i] = (resolve_cond == 3'd1) ? 3 : 2;
        end
        if (mbr < 65535) mbr++;
        if (mis && mmp < 65535) mmp++;
        if (mis) begin
          exp_rv = 1'b1;
          exp_rpc = act ? resolve_target : resolve_pc + 32'd4;
        end
      end
      if (stat_clear) begin
        mbr = 0; mmp = 0;
      end
      tick();
      n_cmp++;
      if (redirect_valid !== exp_rv || redirect_pc !== exp_rpc ||
          stat_branches !== 16'(mbr) || stat_mispredicts !== 16'(mmp)) begin
        n_bad++;
        $display("FAIL rand_state[%0d]: rv=%b rpc=%h br=%0d mp=%0d want %b %h %0d %0d",
                 n, redirect_valid, redirect_pc, stat_branches, stat_mispredicts, exp_rv, exp_rpc, mbr, mmp);
      end
    end
    idle();
  endtask

  task automatic test_stat_saturation();
    do_reset();
    drive(32'h00400010, 3'd1, 1'b0, 1'b0, 32'h00400100, 1'b0, 32'h0);
    for (int k = 0; k < 65535; k++) tick();
    n_cmp++;
    if (stat_mispredicts !== 16'hFFFF || stat_branches !== 16'hFFFF) begin
      n_bad++; $display("FAIL stat_fill: br=%h mp=%h want FFFF FFFF", stat_branches, stat_mispredicts);
    end
    tick();
    n_cmp++;
    if (stat_mispredicts !== 16'hFFFF || stat_branches !== 16'hFFFF) begin
      n_bad++; $display("FAIL stat_saturate: br=%h mp=%h want FFFF FFFF", stat_branches, stat_mispredicts);
    end
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    #1;
    n_cmp++;
    if (stat_mispredicts !== 16'h0 || stat_branches !== 16'h0 || redirect_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stat_clear_prio: br=%h mp=%h rv=%b want 0 0 1", stat_branches, stat_mispredicts, redirect_valid);
    end
    tick();
    idle();
    reset_n = 1'b0;
    fetch_pc = 32'h00400010;
    #1;
    n_cmp++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || predict_hit !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: rv=%b rpc=%h hit=%b want 0 0 0", redirect_valid, redirect_pc, predict_hit);
    end
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      fetch_pc = $urandom();
      #1;
      n_cmp++;
      if (redirect_valid !== 1'b0 || predict_hit !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset[%0d]: rv=%b hit=%b pc=%h want 0 0", k, redirect_valid, predict_hit, fetch_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter_decay();
    test_alias();
    test_gtz_lez();
    test_never();
    test_back_to_back();
    test_random();
    test_stat_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_predict.md
PC_PREDICT -- requirements
Module: Pc_predict

Interface
REQ-001 Parameter WIDTH, default 32, PC width in bits.
REQ-002 Parameter ENTRIES, default 16, prediction-table depth; power of two, 2..256.
REQ-003 Parameter STAT_BITS, default 16, width of each statistics counter.
REQ-004 Port list; clock and reset come first:
  clock  input  1  rising-edge clock.
  reset_n  input  1  asynchronous, active-low reset.
  fetch_pc  input  WIDTH  PC being fetched.
  predict_hit  output  1  valid table entry with matching tag for fetch_pc.
  predict_taken  output  1  predicted taken.
  predict_target  output  WIDTH  predicted next PC.
  resolve_valid  input  1  one branch or jump resolves this cycle.
  resolve_pc  input  WIDTH  PC of the resolving instruction.
  resolve_cond  input  3  condition kind (Never, Always, Eq, Ne, Gez, Ltz, Gtz, Lez).
  zeroflag  input  1  ALU zero/compare flag for the resolving instruction.
  zeroreg  input  1  source register equals zero.
  resolve_target  input  WIDTH  computed taken target.
  resolve_pred_taken  input  1  prediction that was made at fetch.
  resolve_pred_target  input  WIDTH  target that was predicted at fetch.
  redirect_valid  output  1  registered mispredict strobe.
  redirect_pc  output  WIDTH  registered corrected PC.
  stat_clear  input  1  synchronous clear of the statistics counters.
  stat_branches  output  STAT_BITS  resolved-branch count.
  stat_mispredicts  output  STAT_BITS  mispredict count.

Function
REQ-005 Each table entry SHALL hold: valid, tag = pc[WIDTH-1:IDX+2], target (WIDTH bits), and a 2-bit saturating counter; IDX = log2(ENTRIES); index = pc[IDX+1:2].
REQ-006 Lookup SHALL be combinational from registered table state: predict_hit = valid && tag match; predict_taken = predict_hit && counter[1]; predict_target = predict_taken ? entry target : fetch_pc+4, with WIDTH-bit wrap-around.
REQ-007 Actual outcome SHALL be: Never=0; Always=1; Eq=zeroflag; Ne=!zeroflag; Gez=!zeroflag; Ltz=zeroflag; Gtz=!zeroflag&&!zeroreg; Lez=zeroflag||zeroreg.
REQ-008 Mispredict SHALL be asserted when resolve_valid && cond!=Never && (actual != resolve_pred_taken || (actual && resolve_target != resolve_pred_target)).
REQ-009 One cycle after a mispredict, redirect_valid SHALL be 1 for exactly one cycle, and redirect_pc SHALL be actual ? resolve_target : resolve_pc+4; otherwise redirect_valid SHALL be 0 and redirect_pc SHALL hold its last value.
REQ-010 On update with resolve_valid && cond!=Never and an entry hit: the counter SHALL increment on taken and decrement on not-taken, saturating at 3 and 0; the target SHALL be written only when taken.
REQ-011 On a miss: if taken, the entry SHALL be allocated (overwriting any prior occupant) with valid=1, tag, target, and counter=3 for Always or 2 otherwise; if not taken, the table SHALL be unchanged.
REQ-012 cond=Never, or resolve_valid=0, SHALL change neither the table, redirect_valid, nor the statistics.
REQ-013 Updates SHALL become visible to lookup on the cycle after the update edge; a same-cycle lookup of the updated index SHALL see the old contents.
REQ-014 stat_branches SHALL increment per update per REQ-010/011 and stat_mispredicts SHALL increment per mispredict; both SHALL saturate at all-ones; stat_clear SHALL zero both and take priority over a same-cycle increment.

Reset
REQ-015 While reset_n=0, asynchronously: all valid=0; all counters=1; all targets and tags=0; redirect_valid=0; redirect_pc=0; both statistics counters=0.
REQ-016 Reset asserted mid-operation SHALL discard any pending redirect; the first cycle after deassertion SHALL show redirect_valid=0 and predict_hit=0 for every fetch_pc.

Structure
REQ-017 The resolve_cond encodings (Never=0..Lez=7) and the counter reset/allocate constants SHALL live in the shared Pc package, alongside the existing Pc_Action codes.
REQ-018 Outcome evaluation (REQ-007) SHALL be a combinational sub-module, Pc_condition; the table and statistics SHALL remain in Pc_predict.

Verification
REQ-019 Reset, then fetch_pc=0x00400010 -> predict_hit=0, predict_taken=0, predict_target=0x00400014.
REQ-020 Resolve pc=0x00400010, cond=Ne, zeroflag=0, target=0x00400100, pred_taken=0 -> the next cycle gives redirect_valid=1 and redirect_pc=0x00400100; a later lookup gives hit=1, taken=1, target=0x00400100.
REQ-021 With the entry from the previous scenario, resolve not-taken twice (cond=Eq, zeroflag=0) -> counter goes 2→1→0 and predict_taken=0; a third not-taken stays at 0, and stat_branches=3.
REQ-022 Tag alias: ENTRIES=16, allocate 0x00400010, then resolve taken at 0x00400050 (same index) -> the old entry is replaced; a lookup of 0x00400010 gives hit=0.
REQ-023 Gtz with zeroflag=0, zeroreg=1 -> actual=0; Lez with the same inputs -> actual=1; the redirect follows REQ-009.
REQ-024 Drive stat_mispredicts to 0xFFFF, then cause a mispredict -> it stays 0xFFFF; stat_clear together with a mispredict -> 0; assert reset_n low while redirect is pending -> redirect_valid=0 immediately.
